// File: rtl/mux_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_port_arbiter
// Purpose  : 4-requester round-robin arbiter driving one shared SIZE-bit port.
// Option   : MUX_ARB_BURST_LIMIT_EN enables the MAX_BURST grant-length limit.
// Revision : 1.0 - initial release
// ============================================================================
module mux_port_arbiter #(
  parameter int SIZE      = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [4*SIZE-1:0] din,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              valid,
  output logic [SIZE-1:0]   z
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        valid_q, valid_d;

  logic [1:0]  w_rr_win;
  logic [1:0]  w_idx;
  logic [3:0]  w_owner_mask;
  logic        w_other;
  logic        w_owner_req;
  logic        w_take;

  // Scan farthest-first so the nearest requester after ptr is written last.
  always_comb begin
    w_rr_win = ptr_q;
    w_idx    = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      w_idx = ptr_q + 2'(k);
      if (req[w_idx]) begin
        w_rr_win = w_idx;
      end
    end
  end

  assign w_owner_mask = 4'b0001 << sel_q;
  assign w_other      = |(req & ~w_owner_mask);
  assign w_owner_req  = req[sel_q];

`ifdef MUX_ARB_BURST_LIMIT_EN
  localparam logic [3:0] c_cnt_max = 4'(MAX_BURST - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       w_burst_done;

  assign w_burst_done = (cnt_q == c_cnt_max) && w_other;

  always_comb begin
    cnt_d = cnt_q;
    if (w_take) begin
      cnt_d = 4'd0;
    end else if ((state_q == ST_GRANT) && (cnt_q != c_cnt_max)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic       w_burst_done;
  logic [3:0] w_unused_max_burst;

  assign w_burst_done       = 1'b0;
  assign w_unused_max_burst = 4'(MAX_BURST);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    w_take  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          w_take = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!w_owner_req) begin
          if (w_other) begin
            w_take = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
          end
        end else if (w_burst_done) begin
          w_take = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase

    if (w_take) begin
      state_d = ST_GRANT;
      sel_d   = w_rr_win;
      ptr_d   = w_rr_win;
      gnt_d   = 4'b0001 << w_rr_win;
      valid_d = 1'b1;
    end
  end

  // ptr resets to 3 so requester 0 is first in round-robin order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  logic [SIZE-1:0] w_slice [4];
  logic [SIZE-1:0] w_lvl1  [2];
  logic [SIZE-1:0] w_root;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign w_slice[gi] = din[gi*SIZE +: SIZE];
    end
    for (gi = 0; gi < 2; gi++) begin : g_lvl1
      assign w_lvl1[gi] = sel_q[0] ? w_slice[2*gi+1] : w_slice[2*gi];
    end
  endgenerate

  assign w_root = sel_q[1] ? w_lvl1[1] : w_lvl1[0];

  assign z     = valid_q ? w_root : '0;
  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_port_arbiter
// Purpose  : Directed-vector scoreboard bench for mux_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_port_arbiter;

  localparam int SIZE      = 32;
  localparam int MAX_BURST = 4;

  logic              clk;
  logic              rst;
  logic [3:0]        req;
  logic [4*SIZE-1:0] din;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              valid;
  logic [SIZE-1:0]   z;

  typedef struct {
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic            valid;
    logic [SIZE-1:0] z;
    int              id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;

  mux_port_arbiter #(.SIZE(SIZE), .MAX_BURST(MAX_BURST)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SIZE-1:0] slice(input logic [1:0] i);
    return din[i*SIZE +: SIZE];
  endfunction

  // Expected outputs after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] eg,
                      input logic [1:0] es, input logic ev);
    exp_t e;
    @(negedge clk);
    req     = r;
    e.gnt   = eg;
    e.sel   = es;
    e.valid = ev;
    e.z     = ev ? slice(es) : '0;
    e.id    = step_no;
    step_no++;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (gnt !== 4'b0000 || valid !== 1'b0 || z !== '0) begin
      n_errors++;
      $display("FAIL %s gnt=%b valid=%b z=%h required gnt=0000 valid=0 z=0",
               name, gnt, valid, z);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (gnt !== e.gnt || valid !== e.valid || z !== e.z ||
            (e.valid && sel !== e.sel)) begin
          n_errors++;
          $display("FAIL step%0d gnt=%b sel=%0d valid=%b z=%h required gnt=%b sel=%0d valid=%b z=%h",
                   e.id, gnt, sel, valid, z, e.gnt, e.sel, e.valid, e.z);
        end
      end
    end
  end

  initial begin : stimulus
    int wait_cyc;
    rst = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) din[i*SIZE +: SIZE] = 32'hC0DE_0000 | (32'h1111 * (i + 1));

    #12;
    n_checks++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || valid !== 1'b0 || z !== '0) begin
      n_errors++;
      $display("FAIL reset_state gnt=%b sel=%0d valid=%b z=%h required 0/0/0/0",
               gnt, sel, valid, z);
    end
    @(negedge clk);
    rst = 1'b0;

    // Release then RR from ptr=3: 1 wins over 2 only because 0 is absent.
    step(4'b0110, 4'b0010, 2'd1, 1'b1);
    step(4'b0110, 4'b0010, 2'd1, 1'b1);
    step(4'b1100, 4'b0100, 2'd2, 1'b1);
    step(4'b0000, 4'b0000, 2'd2, 1'b0);
    step(4'b1000, 4'b1000, 2'd3, 1'b1);
    step(4'b0000, 4'b0000, 2'd3, 1'b0);

    // Two contenders held constant.
    for (int c = 0; c < 12; c++) begin
`ifdef MUX_ARB_BURST_LIMIT_EN
      if (((c / MAX_BURST) % 2) == 0) step(4'b0011, 4'b0001, 2'd0, 1'b1);
      else                            step(4'b0011, 4'b0010, 2'd1, 1'b1);
`else
      step(4'b0011, 4'b0001, 2'd0, 1'b1);
`endif
    end
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // Lone requester 3 for 10 cycles, then requester 0 joins.
    for (int c = 0; c < 10; c++) step(4'b1000, 4'b1000, 2'd3, 1'b1);
`ifdef MUX_ARB_BURST_LIMIT_EN
    step(4'b1001, 4'b0001, 2'd0, 1'b1);
    step(4'b1001, 4'b0001, 2'd0, 1'b1);
`else
    step(4'b1001, 4'b1000, 2'd3, 1'b1);
    step(4'b1001, 4'b1000, 2'd3, 1'b1);
`endif

    // Asynchronous reset between edges.
    @(negedge clk);
    req = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    @(posedge clk);
    #1;
    check_idle("reset_held");
    @(negedge clk);
    rst = 1'b0;
    step(4'b1111, 4'b0001, 2'd0, 1'b1);
    step(4'b1111, 4'b0001, 2'd0, 1'b1);
    step(4'b1110, 4'b0010, 2'd1, 1'b1);
    step(4'b0100, 4'b0100, 2'd2, 1'b1);
    step(4'b0000, 4'b0000, 2'd2, 1'b0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
